// File: rtl/addsub_acc_ctrl.sv
// Accumulator controller wrapped around an external combinational add/subtract stage.
// A command is latched in IDLE, run through the adder in EXEC, and offered as a result in DONE.
module addsub_acc_ctrl #(
   parameter int unsigned WIDTH  = 6,
   parameter bit          SAT_EN = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   output logic [WIDTH-1:0] add_x,
   output logic [WIDTH-1:0] add_y,
   output logic             add_sel,
   input  logic [WIDTH-1:0] add_sum,
   input  logic             add_cout,
   input  logic             add_ovf,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] acc,
   output logic             flag_c,
   output logic             flag_v,
   output logic             flag_z,
   output logic             flag_n,
   output logic             ovf_sticky
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StExec = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   localparam logic [1:0] OpClr  = 2'b00;
   localparam logic [1:0] OpLoad = 2'b01;
   localparam logic [1:0] OpAdd  = 2'b10;
   localparam logic [1:0] OpSub  = 2'b11;

   localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

   logic [1:0]       state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             c_q, c_d;
   logic             v_q, v_d;
   logic             sticky_q, sticky_d;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      data_d   = data_q;
      acc_d    = acc_q;
      c_d      = c_q;
      v_d      = v_q;
      sticky_d = sticky_q;
      case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               op_d    = cmd_op;
               data_d  = cmd_data;
               state_d = StExec;
            end
         end
         StExec: begin
            state_d = StDone;
            case (op_q)
               OpClr: begin
                  acc_d    = '0;
                  c_d      = 1'b0;
                  v_d      = 1'b0;
                  sticky_d = 1'b0;
               end
               OpLoad: begin
                  acc_d    = data_q;
                  c_d      = 1'b0;
                  v_d      = 1'b0;
                  sticky_d = 1'b0;
               end
               default: begin
                  // Saturation direction follows the sign of the operand already in acc.
                  if (SAT_EN && add_ovf) begin
                     acc_d = acc_q[WIDTH-1] ? MinNeg : MaxPos;
                  end else begin
                     acc_d = add_sum;
                  end
                  c_d      = add_cout;
                  v_d      = add_ovf;
                  sticky_d = sticky_q | add_ovf;
               end
            endcase
         end
         StDone: begin
            if (res_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         op_q     <= 2'b00;
         data_q   <= '0;
         acc_q    <= '0;
         c_q      <= 1'b0;
         v_q      <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         data_q   <= data_d;
         acc_q    <= acc_d;
         c_q      <= c_d;
         v_q      <= v_d;
         sticky_q <= sticky_d;
      end
   end

   assign cmd_ready  = (state_q == StIdle);
   assign res_valid  = (state_q == StDone);
   assign add_x      = acc_q;
   assign add_y      = (state_q == StExec) ? data_q : '0;
   assign add_sel    = (state_q == StExec) && (op_q == OpSub);
   assign acc        = acc_q;
   assign flag_c     = c_q;
   assign flag_v     = v_q;
   assign flag_z     = (acc_q == '0);
   assign flag_n     = acc_q[WIDTH-1];
   assign ovf_sticky = sticky_q;

endmodule
